// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin front end for one shared W-bit equality comparator.
// Optional signed less-than result is compiled in when CMP_ARB_LT_EN is defined.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  per-requester request valid (N_REQ)
//   req_ready  per-requester accept, one-hot or zero (N_REQ)
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, same packing as req_a
//   rsp_valid  response valid, held until rsp_ready
//   rsp_ready  response consumed
//   rsp_id     requester that owns the response
//   rsp_equal  A == B
//   rsp_lt     signed A < B (constant 0 unless CMP_ARB_LT_EN)
//   busy       high whenever a transaction is in flight
module cmp_arbiter #(
  parameter int N_REQ = 2,
  parameter int W = 32,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_equal,
  output logic               rsp_lt,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;

  logic [ID_W-1:0] grant;
  logic            found;
  logic [ID_W:0]   idx;

  // Scan last_grant+1 .. last_grant+N_REQ, wrapping without a divider.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, last_grant} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ))
        idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready[grant] = 1'b1;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef CMP_ARB_LT_EN
  logic lt_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lt_r <= 1'b0;
    else if (state == CMP)
      lt_r <= $signed(a_r) < $signed(b_r);
  end

  assign rsp_lt = lt_r;
`else
  assign rsp_lt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ-1);
      id_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      rsp_id     <= '0;
      rsp_equal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_r        <= req_a[int'(grant)*W +: W];
            b_r        <= req_b[int'(grant)*W +: W];
            id_r       <= grant;
            last_grant <= grant;
            state      <= CMP;
          end
        end
        CMP: begin
          rsp_equal <= (a_r == b_r);
          rsp_id    <= id_r;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: scoreboard bench for cmp_arbiter with N_REQ=4.
// Directed corner cases followed by a randomized traffic phase.
module tb_cmp_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic           rsp_equal;
  logic           rsp_lt;
  logic           busy;

  always #5 clk = ~clk;

  cmp_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_equal(rsp_equal),
    .rsp_lt(rsp_lt), .busy(busy)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic          eq;
    logic          lt;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  int   grants[$];
  logic [W-1:0] sp [4] = '{32'h8000_0000, 32'h7FFF_FFFF,
                           32'hFFFF_FFFF, 32'h0000_0000};

  function automatic void chk(string n, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               n, act, exp, $time);
    end
  endfunction

  function automatic exp_t ref_rsp(int id, logic [W-1:0] a,
                                   logic [W-1:0] b);
    exp_t e;
    e.id = IW'(id);
    e.eq = (a == b);
`ifdef CMP_ARB_LT_EN
    e.lt = ($signed(a) < $signed(b));
`else
    e.lt = 1'b0;
`endif
    return e;
  endfunction

  // Reference model: one transaction in flight at a time, response
  // two cycles after acceptance, next grant only after consumption.
  int m_cyc = 0;
  int acc_cyc = 0;
  bit outst = 1'b0;
  int last = N-1;

  always @(negedge clk) begin
    logic [N-1:0] er;
    logic         erv;
    int           pick;
    m_cyc++;
    if (!reset) begin
      outst = 1'b0;
      last  = N-1;
      grants.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_equal", rsp_equal, 0);
      chk("rst_rsp_lt", rsp_lt, 0);
    end else begin
      er   = '0;
      pick = -1;
      if (!outst) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last + k) % N;
          if (pick < 0 && req_valid[j])
            pick = j;
        end
      end
      if (pick >= 0)
        er[pick] = 1'b1;
      erv = outst && (m_cyc - acc_cyc >= 2);
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, erv);
      chk("busy", busy, outst);
      if (pick >= 0) begin
        sbq.push_back(ref_rsp(pick, req_a[pick*W +: W],
                              req_b[pick*W +: W]));
        grants.push_back(pick);
        outst   = 1'b1;
        acc_cyc = m_cyc;
        last    = pick;
      end else if (erv && rsp_ready) begin
        outst = 1'b0;
      end
    end
  end

  // Monitor: compare each presented response with the scoreboard head,
  // and check that fields keep their last values once rsp_valid falls.
  exp_t lastv = '0;

  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      lastv = '0;
    end else if (rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        chk("rsp_id", rsp_id, sbq[0].id);
        chk("rsp_equal", rsp_equal, sbq[0].eq);
        chk("rsp_lt", rsp_lt, sbq[0].lt);
        if (rsp_ready)
          lastv = sbq.pop_front();
      end
    end else begin
      chk("hold_id", rsp_id, lastv.id);
      chk("hold_equal", rsp_equal, lastv.eq);
      chk("hold_lt", rsp_lt, lastv.lt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void set_ops(int i, logic [W-1:0] a,
                                  logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endfunction

  function automatic void rnd_ops(int i);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: b = a;
      1: b = a ^ (32'h1 << $urandom_range(0, W-1));
      2: begin
        a = sp[$urandom_range(0, 3)];
        b = sp[$urandom_range(0, 3)];
      end
      default: ;
    endcase
    set_ops(i, a, b);
  endfunction

  task automatic wait_take(int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i])
        ok = 1'b1;
    end
    chk("take_timeout", ok, 1);
    tick();
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid)
        ok = 1'b1;
    end
    chk("rsp_timeout", ok, 1);
    tick();
  endtask

  task automatic send(int i, logic [W-1:0] a, logic [W-1:0] b,
                      int hold);
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    wait_take(i);
    req_valid[i] = 1'b0;
    wait_rsp();
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int           rr_exp [5];
    logic [N-1:0] taken;
    rr_exp = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) tick();

    send(0, 32'h1234_5678, 32'h1234_5678, 3);
    send(1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    send(0, 32'h0000_0005, 32'h0000_0006, 0);

    set_ops(2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    req_valid[2] = 1'b1;
    wait_take(2);
    req_valid[2] = 1'b0;
    wait_rsp();
    rsp_ready = 1'b1;
    set_ops(3, 32'h0000_0010, 32'h0000_0020);
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_cycle", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    wait_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    set_ops(2, 32'h0000_00AA, 32'h0000_00AA);
    req_valid[2] = 1'b1;
    wait_take(2);
    req_valid[2] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    repeat (2) tick();
    set_ops(0, 32'd7, 32'd7);
    set_ops(1, 32'd5, 32'd6);
    set_ops(2, 32'd1, 32'd2);
    set_ops(3, 32'd9, 32'd9);
    req_valid = '1;
    rsp_ready = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++)
        if (taken[i]) rnd_ops(i);
    end
    req_valid = '0;
    chk("rr_count", grants.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < grants.size()) ? grants[k] : -1,
          rr_exp[k]);
    repeat (4) tick();
    rsp_ready = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          rnd_ops(i);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            rnd_ops(i);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
